btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning log2 of table entries (16 entries).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_pc_IF  input  32  fetch-stage PC to predict.
REQ-005 SHALL have port o_pred_taken  output  1  IF-stage prediction: redirect fetch.
REQ-006 SHALL have port o_pred_target  output  32  next fetch PC, predicted target or i_pc_IF+4.
REQ-007 SHALL have port i_upd_valid  input  1  EX holds a branch or jump (resolved this cycle).
REQ-008 SHALL have port i_pc_EX  input  32  PC of the resolving instruction.
REQ-009 SHALL have port i_taken_EX  input  1  actual outcome; 1 for every jump.
REQ-010 SHALL have port i_target_EX  input  32  actual computed target.
REQ-011 SHALL have port i_pred_taken_EX  input  1  prediction piped down from IF for this instruction.
REQ-012 SHALL have port i_pred_target_EX  input  32  predicted next PC piped down from IF.
REQ-013 SHALL have port o_mispred  output  1  EX-stage mispredict: flush IF/ID and redirect.
REQ-014 SHALL have port o_pc_redirect  output  32  corrected PC when o_mispred=1.
REQ-015 SHALL have port o_br_cnt  output  32  count of resolved control instructions.
REQ-016 SHALL have port o_mispred_cnt  output  32  count of mispredictions.

Function
REQ-017 SHALL hold 2^INDEX_W entries, each: valid (1), tag (32-INDEX_W-2 bits), target (32), 2-bit saturating counter.
REQ-018 SHALL index with pc[INDEX_W+1:2], tag with pc[31:INDEX_W+2]; pc[1:0] ignored.
REQ-019 SHALL compute prediction combinationally, zero-cycle latency: hit = valid & tag match; o_pred_taken = hit & counter[1].
REQ-020 SHALL drive o_pred_target = entry target when o_pred_taken=1, else i_pc_IF+4 (mod 2^32).
REQ-021 SHALL assert o_mispred = i_upd_valid & ((i_taken_EX != i_pred_taken_EX) | (i_taken_EX & i_target_EX != i_pred_target_EX)), combinationally.
REQ-022 SHALL drive o_pc_redirect = i_target_EX if i_taken_EX, else i_pc_EX+4.
REQ-023 SHALL, on rising edge with i_upd_valid=1 and EX-index entry hit: counter +1 saturating at 2'b11 if taken, -1 saturating at 2'b00 if not taken; target overwritten with i_target_EX if taken.
REQ-024 SHALL, on update miss with i_taken_EX=1: allocate/overwrite entry (valid=1, tag, target=i_target_EX, counter=2'b10).
REQ-025 SHALL, on update miss with i_taken_EX=0: leave table unchanged.
REQ-026 SHALL leave table unchanged when i_upd_valid=0.
REQ-027 SHALL, when IF and EX hit the same index in one cycle, return pre-update contents to IF (no write-through bypass).
REQ-028 SHALL increment o_br_cnt on every edge with i_upd_valid=1, and o_mispred_cnt when additionally o_mispred=1; both wrap 2^32-1 -> 0.

Reset
REQ-029 SHALL, while i_rst_n=0, asynchronously clear all valid bits, targets to 0, counters to 2'b01, o_br_cnt and o_mispred_cnt to 0.
REQ-030 SHALL, from reset, output o_pred_taken=0, o_pred_target=i_pc_IF+4 for any PC.
REQ-031 SHALL discard any update coinciding with reset assertion; first update takes effect on first rising edge after i_rst_n=1.

Verification
REQ-032 SHALL cover cold miss: after reset, i_pc_IF=0x100 -> o_pred_taken=0, o_pred_target=0x104.
REQ-033 SHALL cover allocate: update pc_EX=0x100, taken=1, target=0x200, pred_taken=0 -> o_mispred=1, o_pc_redirect=0x200; next cycle i_pc_IF=0x100 -> pred_taken=1, target=0x200.
REQ-034 SHALL cover hysteresis: from counter 2'b10, one not-taken update -> 2'b01, prediction 0; mispred=1, redirect=0x104; two taken updates -> 2'b11, third taken stays 2'b11.
REQ-035 SHALL cover aliasing: entry at 0x100 valid; i_pc_IF=0x140 (same index, INDEX_W=4) -> tag miss, pred_taken=0.
REQ-036 SHALL cover same-cycle read/update at 0x100 with counter 2'b01 and taken update -> IF sees pred_taken=0 that cycle, 1 next cycle.
REQ-037 SHALL cover counter wrap and reset mid-run: o_br_cnt preloaded near 0xFFFFFFFF wraps to 0; i_rst_n low mid-sequence -> all outputs/counters per REQ-029 immediately.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters. Prediction and mispredict are combinational (0 cycles).
// Table and counter updates take effect on the next clock edge. There is no backpressure: one update is accepted per cycle.
module btb_predictor #(
  parameter int INDEX_W = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_IF,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_pc_EX,
  input  logic        i_taken_EX,
  input  logic [31:0] i_target_EX,
  input  logic        i_pred_taken_EX,
  input  logic [31:0] i_pred_target_EX,
  output logic        o_mispred,
  output logic [31:0] o_pc_redirect,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 32 - INDEX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  logic [INDEX_W-1:0] if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;
  logic [INDEX_W-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  logic               ex_hit;
  logic [1:0]         ctr_nxt;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^{i_pc_IF[1:0], i_pc_EX[1:0]};

  assign if_idx = i_pc_IF[INDEX_W+1:2];
  assign if_tag = i_pc_IF[31:INDEX_W+2];
  assign ex_idx = i_pc_EX[INDEX_W+1:2];
  assign ex_tag = i_pc_EX[31:INDEX_W+2];

  // Reads see the registered table only, so a same-cycle update to the same index is not forwarded.
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign o_pred_taken  = if_hit & ctr_q[if_idx][1];
  assign o_pred_target = o_pred_taken ? target_q[if_idx] : i_pc_IF + 32'd4;

  assign o_mispred = i_upd_valid &
                     ((i_taken_EX != i_pred_taken_EX) |
                      (i_taken_EX & (i_target_EX != i_pred_target_EX)));
  assign o_pc_redirect = i_taken_EX ? i_target_EX : i_pc_EX + 32'd4;

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

  always_comb begin
    ctr_nxt = ctr_q[ex_idx];
    if (i_taken_EX && ctr_q[ex_idx] != 2'b11)
      ctr_nxt = ctr_q[ex_idx] + 2'b01;
    else if (!i_taken_EX && ctr_q[ex_idx] != 2'b00)
      ctr_nxt = ctr_q[ex_idx] - 2'b01;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (i_upd_valid) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_nxt;
        if (i_taken_EX)
          target_q[ex_idx] <= i_target_EX;
      end else if (i_taken_EX) begin
        // Taken miss replaces whatever alias occupied the slot, starting weakly taken.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= i_target_EX;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (i_upd_valid) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (o_mispred)
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: hand-computed vectors, one task per scenario.
module tb_btb_predictor;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_pc_IF;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_pc_EX;
  logic        i_taken_EX;
  logic [31:0] i_target_EX;
  logic        i_pred_taken_EX;
  logic [31:0] i_pred_target_EX;
  logic        o_mispred;
  logic [31:0] o_pc_redirect;
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  btb_predictor #(.INDEX_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pc_IF(i_pc_IF), .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .i_upd_valid(i_upd_valid), .i_pc_EX(i_pc_EX), .i_taken_EX(i_taken_EX),
    .i_target_EX(i_target_EX), .i_pred_taken_EX(i_pred_taken_EX),
    .i_pred_target_EX(i_pred_target_EX), .o_mispred(o_mispred),
    .o_pc_redirect(o_pc_redirect), .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach summary, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    i_upd_valid = v; i_pc_EX = pc; i_taken_EX = tk; i_target_EX = tgt;
    i_pred_taken_EX = ptk; i_pred_target_EX = ptgt;
  endtask

  task automatic test_reset();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    i_pc_IF = 32'h100;
    i_rst_n = 1'b0;
    #12;
    i_rst_n = 1'b1;
    tick();
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h104}) begin
      n_err++; $display("FAIL reset_cold_miss: got %b/%h want 0/00000104", o_pred_taken, o_pred_target);
    end
    n_vec++;
    if ({o_br_cnt, o_mispred_cnt} !== 64'h0) begin
      n_err++; $display("FAIL reset_counters: got %h/%h want 0/0", o_br_cnt, o_mispred_cnt);
    end
    i_pc_IF = 32'hFFFF_FFFC;
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_pc_wrap: got %b/%h want 0/00000000", o_pred_taken, o_pred_target);
    end
    n_vec++;
    if (o_mispred !== 1'b0) begin
      n_err++; $display("FAIL idle_no_mispred: got %b want 0", o_mispred);
    end
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    i_pc_IF = 32'h100;
    #1;
    n_vec++;
    if ({o_mispred, o_pc_redirect} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL alloc_mispred: got %b/%h want 1/00000200", o_mispred, o_pc_redirect);
    end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL alloc_predict: got %b/%h want 1/00000200", o_pred_taken, o_pred_target);
    end
    n_vec++;
    if ({o_br_cnt, o_mispred_cnt} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL alloc_counts: got %0d/%0d want 1/1", o_br_cnt, o_mispred_cnt);
    end
  endtask

  task automatic test_hysteresis();
    // counter 10 -> not taken -> 01
    i_pc_IF = 32'h100;
    set_upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    n_vec++;
    if ({o_mispred, o_pc_redirect} !== {1'b1, 32'h104}) begin
      n_err++; $display("FAIL hyst_nt_mispred: got %b/%h want 1/00000104", o_mispred, o_pc_redirect);
    end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h104}) begin
      n_err++; $display("FAIL hyst_weak_nt: got %b/%h want 0/00000104", o_pred_taken, o_pred_target);
    end
    // 01 -> 10 -> 11 -> 11 (saturate)
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    #1;
    n_vec++;
    if (o_mispred !== 1'b0) begin
      n_err++; $display("FAIL hyst_correct_taken: got %b want 0", o_mispred);
    end
    tick();
    tick();
    // if saturated at 11, one not-taken leaves 10 which still predicts taken
    set_upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL hyst_saturate: got %b/%h want 1/00000200", o_pred_taken, o_pred_target);
    end
    n_vec++;
    if ({o_br_cnt, o_mispred_cnt} !== {32'd6, 32'd4}) begin
      n_err++; $display("FAIL hyst_counts: got %0d/%0d want 6/4", o_br_cnt, o_mispred_cnt);
    end
  endtask

  task automatic test_target_change();
    // counter 10, target 0x200; taken to a new target is a mispredict and retargets
    set_upd(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    n_vec++;
    if ({o_mispred, o_pc_redirect} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL retarget_mispred: got %b/%h want 1/00000300", o_mispred, o_pc_redirect);
    end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL retarget_predict: got %b/%h want 1/00000300", o_pred_taken, o_pred_target);
    end
  endtask

  task automatic test_alias();
    i_pc_IF = 32'h140;
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h144}) begin
      n_err++; $display("FAIL alias_tag_miss: got %b/%h want 0/00000144", o_pred_taken, o_pred_target);
    end
    // not-taken miss on an alias and an invalid update must not disturb 0x100
    set_upd(1'b1, 32'h180, 1'b0, 32'h999, 1'b0, 32'h184);
    tick();
    set_upd(1'b0, 32'h140, 1'b1, 32'h444, 1'b0, 32'h144);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h144}) begin
      n_err++; $display("FAIL alias_no_alloc: got %b/%h want 0/00000144", o_pred_taken, o_pred_target);
    end
    i_pc_IF = 32'h100;
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL alias_entry_kept: got %b/%h want 1/00000300", o_pred_taken, o_pred_target);
    end
  endtask

  task automatic test_same_cycle();
    // counter 11 -> two not-taken -> 01
    i_pc_IF = 32'h100;
    set_upd(1'b1, 32'h100, 1'b0, 32'h300, 1'b1, 32'h300);
    tick();
    tick();
    set_upd(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h104}) begin
      n_err++; $display("FAIL same_cycle_old: got %b/%h want 0/00000104", o_pred_taken, o_pred_target);
    end
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL same_cycle_new: got %b/%h want 1/00000300", o_pred_taken, o_pred_target);
    end
  endtask

  task automatic test_wrap_and_reset();
    @(negedge i_clk);
    dut.br_cnt_q      = 32'hFFFF_FFFE;
    dut.mispred_cnt_q = 32'hFFFF_FFFF;
    set_upd(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
    tick();
    n_vec++;
    if ({o_br_cnt, o_mispred_cnt} !== {32'hFFFF_FFFF, 32'h0}) begin
      n_err++; $display("FAIL wrap_mispred_cnt: got %h/%h want ffffffff/00000000", o_br_cnt, o_mispred_cnt);
    end
    set_upd(1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 32'h208);
    tick();
    n_vec++;
    if ({o_br_cnt, o_mispred_cnt} !== {32'h0, 32'h0}) begin
      n_err++; $display("FAIL wrap_br_cnt: got %h/%h want 0/0", o_br_cnt, o_mispred_cnt);
    end
    // reset mid-cycle with an update pending
    set_upd(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
    i_pc_IF = 32'h200;
    #2;
    i_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target} !== {1'b0, 32'h204}) begin
      n_err++; $display("FAIL midreset_table: got %b/%h want 0/00000204", o_pred_taken, o_pred_target);
    end
    n_vec++;
    if ({o_br_cnt, o_mispred_cnt} !== 64'h0) begin
      n_err++; $display("FAIL midreset_counts: got %h/%h want 0/0", o_br_cnt, o_mispred_cnt);
    end
    tick();
    i_pc_IF = 32'h300;
    #1;
    n_vec++;
    if ({o_pred_taken, o_br_cnt} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL midreset_discard: got %b/%h want 0/00000000", o_pred_taken, o_br_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    #1;
    n_vec++;
    if ({o_pred_taken, o_pred_target, o_br_cnt, o_mispred_cnt} !== {1'b1, 32'h500, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL postreset_update: got %b/%h/%0d/%0d want 1/00000500/1/1",
                        o_pred_taken, o_pred_target, o_br_cnt, o_mispred_cnt);
    end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_target_change();
    test_alias();
    test_same_cycle();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
